// File: rtl/mrd_rdx3_gather_if.sv
// Bus between the serial sample source, the radix-3 gather stage and the butterfly.
// The source drives the sin_* side; the gather stage drives the grouped outputs.
interface mrd_rdx3_gather_if #(
  parameter int unsigned W_DATA = 18
);
  logic              sin_val;
  logic              sin_sop;
  logic [W_DATA-1:0] sin_real;
  logic [W_DATA-1:0] sin_imag;
  logic [3:0]        exp_in;
  logic              out_val;
  logic [W_DATA-1:0] dout_real [0:4];
  logic [W_DATA-1:0] dout_imag [0:4];
  logic [1:0]        margin_out;
  logic [3:0]        exp_out;
  logic              err_frag;

  modport master (
    output sin_val, sin_sop, sin_real, sin_imag, exp_in,
    input  out_val, dout_real, dout_imag, margin_out, exp_out, err_frag
  );

  modport slave (
    input  sin_val, sin_sop, sin_real, sin_imag, exp_in,
    output out_val, dout_real, dout_imag, margin_out, exp_out, err_frag
  );
endinterface

// File: rtl/mrd_rdx3_gather.sv
// Packs three serial complex samples into the 5-lane radix-3 butterfly bus,
// tracking group headroom and forwarding the block exponent.
module mrd_rdx3_gather #(
  parameter int unsigned W_DATA = 18
) (
  input logic              clk,
  input logic              rst_n,
  mrd_rdx3_gather_if.slave bus
);
  typedef enum logic {S_IDLE, S_COLLECT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [W_DATA-1:0] stg_re_q [0:1];
  logic [W_DATA-1:0] stg_re_d [0:1];
  logic [W_DATA-1:0] stg_im_q [0:1];
  logic [W_DATA-1:0] stg_im_d [0:1];
  logic [1:0]        marg_q, marg_d;
  logic [3:0]        exp_hold_q, exp_hold_d;
  logic [W_DATA-1:0] out_re_q [0:2];
  logic [W_DATA-1:0] out_re_d [0:2];
  logic [W_DATA-1:0] out_im_q [0:2];
  logic [W_DATA-1:0] out_im_d [0:2];
  logic [1:0]        margin_q, margin_d;
  logic [3:0]        exp_out_q, exp_out_d;
  logic              out_val_q, out_val_d;
  logic              err_frag_q, err_frag_d;
  logic [1:0]        samp_m_c;

  // Redundant sign bits below the MSB, saturated at 3.
  function automatic logic [1:0] head_m(input logic [W_DATA-1:0] v);
    logic s;
    s = v[W_DATA-1];
    if (v[W_DATA-2] != s)      return 2'd0;
    else if (v[W_DATA-3] != s) return 2'd1;
    else if (v[W_DATA-4] != s) return 2'd2;
    else                       return 2'd3;
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign samp_m_c = min2(head_m(bus.sin_real), head_m(bus.sin_imag));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stg_re_d   = stg_re_q;
    stg_im_d   = stg_im_q;
    marg_d     = marg_q;
    exp_hold_d = exp_hold_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    margin_d   = margin_q;
    exp_out_d  = exp_out_q;
    out_val_d  = 1'b0;
    err_frag_d = 1'b0;

    if (bus.sin_val && bus.sin_sop) begin
      // SOP always restarts at lane 0, dropping any partial group.
      state_d     = S_COLLECT;
      cnt_d       = 2'd1;
      stg_re_d[0] = bus.sin_real;
      stg_im_d[0] = bus.sin_imag;
      marg_d      = samp_m_c;
      exp_hold_d  = bus.exp_in;
      err_frag_d  = (state_q == S_COLLECT) && (cnt_q != 2'd0);
    end else if (bus.sin_val && (state_q == S_COLLECT)) begin
      case (cnt_q)
        2'd0: begin
          stg_re_d[0] = bus.sin_real;
          stg_im_d[0] = bus.sin_imag;
          marg_d      = samp_m_c;
          cnt_d       = 2'd1;
        end
        2'd1: begin
          stg_re_d[1] = bus.sin_real;
          stg_im_d[1] = bus.sin_imag;
          marg_d      = min2(marg_q, samp_m_c);
          cnt_d       = 2'd2;
        end
        default: begin
          out_re_d[0] = stg_re_q[0];
          out_im_d[0] = stg_im_q[0];
          out_re_d[1] = stg_re_q[1];
          out_im_d[1] = stg_im_q[1];
          out_re_d[2] = bus.sin_real;
          out_im_d[2] = bus.sin_imag;
          margin_d    = min2(marg_q, samp_m_c);
          exp_out_d   = exp_hold_q;
          out_val_d   = 1'b1;
          cnt_d       = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      marg_q     <= 2'd0;
      exp_hold_q <= 4'd0;
      margin_q   <= 2'd0;
      exp_out_q  <= 4'd0;
      out_val_q  <= 1'b0;
      err_frag_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        stg_re_q[i] <= '0;
        stg_im_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        out_re_q[i] <= '0;
        out_im_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stg_re_q   <= stg_re_d;
      stg_im_q   <= stg_im_d;
      marg_q     <= marg_d;
      exp_hold_q <= exp_hold_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
      margin_q   <= margin_d;
      exp_out_q  <= exp_out_d;
      out_val_q  <= out_val_d;
      err_frag_q <= err_frag_d;
    end
  end

  assign bus.out_val      = out_val_q;
  assign bus.err_frag     = err_frag_q;
  assign bus.margin_out   = margin_q;
  assign bus.exp_out      = exp_out_q;
  assign bus.dout_real[0] = out_re_q[0];
  assign bus.dout_real[1] = out_re_q[1];
  assign bus.dout_real[2] = out_re_q[2];
  assign bus.dout_real[3] = '0;
  assign bus.dout_real[4] = '0;
  assign bus.dout_imag[0] = out_im_q[0];
  assign bus.dout_imag[1] = out_im_q[1];
  assign bus.dout_imag[2] = out_im_q[2];
  assign bus.dout_imag[3] = '0;
  assign bus.dout_imag[4] = '0;
endmodule

// File: tb/tb_mrd_rdx3_gather.sv
// Directed bench for mrd_rdx3_gather: reset, grouping, headroom, gaps,
// fragment recovery and back-to-back groups.
module tb_mrd_rdx3_gather;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [17:0] er [0:4];
  logic [17:0] ei [0:4];

  mrd_rdx3_gather_if #(.W_DATA(18)) bus ();

  mrd_rdx3_gather #(.W_DATA(18)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic sop, input logic [17:0] re,
                       input logic [17:0] im, input logic [3:0] e);
    bus.sin_val  = v;
    bus.sin_sop  = sop;
    bus.sin_real = re;
    bus.sin_imag = im;
    bus.exp_in   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [17:0] r0, input logic [17:0] i0,
                         input logic [17:0] r1, input logic [17:0] i1,
                         input logic [17:0] r2, input logic [17:0] i2);
    er[0] = r0; ei[0] = i0;
    er[1] = r1; ei[1] = i1;
    er[2] = r2; ei[2] = i2;
    er[3] = '0; ei[3] = '0;
    er[4] = '0; ei[4] = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(1'($urandom), 1'($urandom), 18'($urandom), 18'($urandom), 4'($urandom));
      checks++;
      if (bus.out_val !== 1'b0 || bus.err_frag !== 1'b0) begin
        errors++;
        $display("FAIL reset_pulses cyc%0d: out_val=%b err_frag=%b expected 0/0", c, bus.out_val, bus.err_frag);
      end
    end
    set_exp('0, '0, '0, '0, '0, '0);
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (bus.dout_real[l] !== er[l] || bus.dout_imag[l] !== ei[l]) begin
        errors++;
        $display("FAIL reset_lane%0d: got %h/%h expected 0/0", l, bus.dout_real[l], bus.dout_imag[l]);
      end
    end
    checks++;
    if (bus.margin_out !== 2'd0 || bus.exp_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_meta: margin=%0d exp=%0d expected 0/0", bus.margin_out, bus.exp_out);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 18'(c), 18'(c + 1), 4'd1);
      checks++;
      if (bus.out_val !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_sop cyc%0d: out_val=%b expected 0", c, bus.out_val);
      end
    end
  endtask

  task automatic test_nominal();
    drive(1'b1, 1'b1, 18'h1ffff, 18'h00000, 4'd5);
    checks++;
    if (bus.out_val !== 1'b0) begin errors++; $display("FAIL nominal_s1: out_val=%b expected 0", bus.out_val); end
    drive(1'b1, 1'b0, 18'h30000, 18'h1ffff, 4'd0);
    checks++;
    if (bus.out_val !== 1'b0) begin errors++; $display("FAIL nominal_s2: out_val=%b expected 0", bus.out_val); end
    drive(1'b1, 1'b0, 18'h30000, 18'h20000, 4'd0);
    checks++;
    if (bus.out_val !== 1'b1) begin errors++; $display("FAIL nominal_val: out_val=%b expected 1", bus.out_val); end
    set_exp(18'h1ffff, 18'h00000, 18'h30000, 18'h1ffff, 18'h30000, 18'h20000);
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (bus.dout_real[l] !== er[l] || bus.dout_imag[l] !== ei[l]) begin
        errors++;
        $display("FAIL nominal_lane%0d: got %h/%h expected %h/%h", l, bus.dout_real[l], bus.dout_imag[l], er[l], ei[l]);
      end
    end
    checks++;
    if (bus.margin_out !== 2'd0 || bus.exp_out !== 4'd5) begin
      errors++;
      $display("FAIL nominal_meta: margin=%0d exp=%0d expected 0/5", bus.margin_out, bus.exp_out);
    end
    drive(1'b0, 1'b0, 18'h0, 18'h0, 4'd0);
    checks++;
    if (bus.out_val !== 1'b0 || bus.dout_real[2] !== 18'h30000) begin
      errors++;
      $display("FAIL nominal_after: out_val=%b lane2=%h expected 0/30000", bus.out_val, bus.dout_real[2]);
    end
  endtask

  task automatic test_small();
    drive(1'b1, 1'b1, 18'h00100, 18'h3ff00, 4'd3);
    drive(1'b1, 1'b0, 18'h00020, 18'h00000, 4'd0);
    drive(1'b1, 1'b0, 18'h3fff0, 18'h00001, 4'd0);
    checks++;
    if (bus.out_val !== 1'b1 || bus.margin_out !== 2'd3 || bus.exp_out !== 4'd3) begin
      errors++;
      $display("FAIL small_m3: val=%b margin=%0d exp=%0d expected 1/3/3", bus.out_val, bus.margin_out, bus.exp_out);
    end
    drive(1'b1, 1'b1, 18'h00100, 18'h3ff00, 4'd3);
    checks++;
    if (bus.err_frag !== 1'b0) begin errors++; $display("FAIL small_nofrag: err_frag=%b expected 0", bus.err_frag); end
    drive(1'b1, 1'b0, 18'h00020, 18'h00000, 4'd0);
    drive(1'b1, 1'b0, 18'h30000, 18'h00001, 4'd0);
    checks++;
    if (bus.out_val !== 1'b1 || bus.margin_out !== 2'd1 || bus.dout_real[2] !== 18'h30000) begin
      errors++;
      $display("FAIL small_m1: val=%b margin=%0d lane2=%h expected 1/1/30000", bus.out_val, bus.margin_out, bus.dout_real[2]);
    end
  endtask

  task automatic test_gap();
    logic exp_v;
    for (int c = 0; c < 15; c++) begin
      if (c == 0)      drive(1'b1, 1'b1, 18'h00000, 18'h00001, 4'd2);
      else if (c == 4) drive(1'b1, 1'b0, 18'h00002, 18'h00003, 4'd0);
      else if (c == 9) drive(1'b1, 1'b0, 18'h00004, 18'h00005, 4'd0);
      else             drive(1'b0, 1'b0, 18'h3aaaa, 18'h15555, 4'd9);
      exp_v = (c == 9);
      checks++;
      if (bus.out_val !== exp_v) begin
        errors++;
        $display("FAIL gap_val cyc%0d: out_val=%b expected %b", c + 1, bus.out_val, exp_v);
      end
    end
    set_exp(18'h0, 18'h1, 18'h2, 18'h3, 18'h4, 18'h5);
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (bus.dout_real[l] !== er[l] || bus.dout_imag[l] !== ei[l]) begin
        errors++;
        $display("FAIL gap_hold_lane%0d: got %h/%h expected %h/%h", l, bus.dout_real[l], bus.dout_imag[l], er[l], ei[l]);
      end
    end
    checks++;
    if (bus.exp_out !== 4'd2 || bus.margin_out !== 2'd3) begin
      errors++;
      $display("FAIL gap_meta: exp=%0d margin=%0d expected 2/3", bus.exp_out, bus.margin_out);
    end
  endtask

  task automatic test_fragment();
    drive(1'b1, 1'b1, 18'h00011, 18'h00012, 4'd4);
    drive(1'b1, 1'b0, 18'h00013, 18'h00014, 4'd0);
    checks++;
    if (bus.out_val !== 1'b0 || bus.err_frag !== 1'b0) begin
      errors++;
      $display("FAIL frag_pre: val=%b err=%b expected 0/0", bus.out_val, bus.err_frag);
    end
    drive(1'b1, 1'b1, 18'h00021, 18'h00022, 4'd7);
    checks++;
    if (bus.err_frag !== 1'b1 || bus.out_val !== 1'b0) begin
      errors++;
      $display("FAIL frag_pulse: err=%b val=%b expected 1/0", bus.err_frag, bus.out_val);
    end
    drive(1'b1, 1'b0, 18'h00023, 18'h00024, 4'd0);
    checks++;
    if (bus.err_frag !== 1'b0 || bus.out_val !== 1'b0) begin
      errors++;
      $display("FAIL frag_once: err=%b val=%b expected 0/0", bus.err_frag, bus.out_val);
    end
    drive(1'b1, 1'b0, 18'h00025, 18'h00026, 4'd0);
    checks++;
    if (bus.out_val !== 1'b1 || bus.exp_out !== 4'd7 || bus.err_frag !== 1'b0) begin
      errors++;
      $display("FAIL frag_group2: val=%b exp=%0d err=%b expected 1/7/0", bus.out_val, bus.exp_out, bus.err_frag);
    end
    set_exp(18'h21, 18'h22, 18'h23, 18'h24, 18'h25, 18'h26);
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (bus.dout_real[l] !== er[l] || bus.dout_imag[l] !== ei[l]) begin
        errors++;
        $display("FAIL frag_lane%0d: got %h/%h expected %h/%h", l, bus.dout_real[l], bus.dout_imag[l], er[l], ei[l]);
      end
    end
  endtask

  // Sample k of the back-to-back stream; k=5 and k=8 lower the headroom.
  function automatic logic [17:0] b2b_re(input int k);
    return (k == 5) ? 18'h20000 : 18'(k);
  endfunction
  function automatic logic [17:0] b2b_im(input int k);
    return (k == 8) ? 18'h08000 : 18'(-k);
  endfunction

  task automatic test_back_to_back();
    logic       exp_v;
    logic [1:0] exp_m;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, (k == 1), b2b_re(k), b2b_im(k), 4'd6);
      exp_v = (k % 3 == 0);
      checks++;
      if (bus.out_val !== exp_v) begin
        errors++;
        $display("FAIL b2b_val s%0d: out_val=%b expected %b", k, bus.out_val, exp_v);
      end
      if (exp_v) begin
        set_exp(b2b_re(k - 2), b2b_im(k - 2), b2b_re(k - 1), b2b_im(k - 1), b2b_re(k), b2b_im(k));
        exp_m = (k == 3) ? 2'd3 : (k == 6) ? 2'd0 : 2'd1;
        for (int l = 0; l < 5; l++) begin
          checks++;
          if (bus.dout_real[l] !== er[l] || bus.dout_imag[l] !== ei[l]) begin
            errors++;
            $display("FAIL b2b_g%0d_lane%0d: got %h/%h expected %h/%h", k / 3, l,
                     bus.dout_real[l], bus.dout_imag[l], er[l], ei[l]);
          end
        end
        checks++;
        if (bus.margin_out !== exp_m || bus.exp_out !== 4'd6) begin
          errors++;
          $display("FAIL b2b_g%0d_meta: margin=%0d exp=%0d expected %0d/6", k / 3, bus.margin_out, bus.exp_out, exp_m);
        end
      end
    end
    drive(1'b1, 1'b0, b2b_re(10), b2b_im(10), 4'd0);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 18'h00011, 18'h00012, 4'd0);
    checks++;
    if (bus.out_val !== 1'b0 || bus.err_frag !== 1'b0 || bus.margin_out !== 2'd0 || bus.exp_out !== 4'd0) begin
      errors++;
      $display("FAIL b2b_rst_meta: val=%b err=%b margin=%0d exp=%0d expected all 0",
               bus.out_val, bus.err_frag, bus.margin_out, bus.exp_out);
    end
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (bus.dout_real[l] !== 18'h0 || bus.dout_imag[l] !== 18'h0) begin
        errors++;
        $display("FAIL b2b_rst_lane%0d: got %h/%h expected 0/0", l, bus.dout_real[l], bus.dout_imag[l]);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 18'(c), 18'(c), 4'd0);
      checks++;
      if (bus.out_val !== 1'b0 || bus.err_frag !== 1'b0) begin
        errors++;
        $display("FAIL b2b_post_rst cyc%0d: val=%b err=%b expected 0/0", c, bus.out_val, bus.err_frag);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.sin_val  = 1'b0;
    bus.sin_sop  = 1'b0;
    bus.sin_real = '0;
    bus.sin_imag = '0;
    bus.exp_in   = '0;
    test_reset();
    test_nominal();
    test_small();
    test_gap();
    test_fragment();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
